spm_read_streamer: RTL and testbench

- Front-end sequencer for the scratchpad single-port RAM. It issues a burst of strided reads and collects each word from the RAM's one-cycle read port.
- Collected words go out on a valid/ready stream toward the downstream compute stage.
- It absorbs backpressure with a small credit-managed FIFO, so no RAM read result is ever lost.

---
 rtl/spm_read_streamer_pkg.sv | 15 +
 rtl/spm_read_streamer_stream_fifo.sv | 55 +++++
 rtl/spm_read_streamer.sv | 164 ++++++++++++++++
 tb/tb_spm_read_streamer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spm_read_streamer_pkg.sv
// Shared definitions for the scratchpad read streamer.
// Holds the FSM state encoding and the default widths used by the top and its FIFO.
// The default data width is 32 bits.
package spm_read_streamer_pkg;

   localparam int SPM_DW    = 32;
   localparam int SPM_AW    = 9;
   localparam int SPM_LW    = 10;
   localparam int SPM_DEPTH = 2;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;

endpackage

// File: rtl/spm_read_streamer_stream_fifo.sv
// Purpose: DEPTH x DW synchronous FIFO holding RAM read words for the output stream.
// Latency: a pushed word is visible at head_o the cycle after the push.
// Backpressure: none internally; the caller keeps push away from a full FIFO.
// Ports: clk_i/rst_i (async active-high), clear_i empties the FIFO, push_i/push_data_i write,
//        pop_i advances the head, head_o/count_o/empty_o/full_o report state.
module stream_fifo #(
   parameter int DW    = 32,
   parameter int DEPTH = 2
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         clear_i,
   input  logic                         push_i,
   input  logic [DW-1:0]                push_data_i,
   input  logic                         pop_i,
   output logic [DW-1:0]                head_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_o,
   output logic                         empty_o,
   output logic                         full_o
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH+1);

   logic [DW-1:0] mem_q [DEPTH];
   logic [PW-1:0] wr_q, rd_q;
   logic [CW-1:0] count_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else if (clear_i) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else begin
         if (push_i) wr_q <= wr_q + PW'(1);
         if (pop_i)  rd_q <= rd_q + PW'(1);
         if (push_i && !pop_i)      count_q <= count_q + CW'(1);
         else if (!push_i && pop_i) count_q <= count_q - CW'(1);
      end
   end

   // Storage needs no reset: the head is only consumed while count is non-zero.
   always_ff @(posedge clk_i) begin
      if (push_i && !clear_i) mem_q[wr_q] <= push_data_i;
   end

   assign head_o  = mem_q[rd_q];
   assign count_o = count_q;
   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CW'(DEPTH));

endmodule

// File: rtl/spm_read_streamer.sv
// Purpose: issues a strided read burst to a single-port RAM and streams the words out.
// Latency: first word on out_data two cycles after the first RUN cycle; one word/cycle sustained.
// Backpressure: out_ready stalls issue through FIFO credits, so no read result is dropped.
// Ports: start/abort/base_addr/stride/len control, busy/done status, ram_* to the RAM,
//        out_valid/out_ready/out_data/out_last downstream stream.
module spm_read_streamer
   import spm_read_streamer_pkg::*;
#(
   parameter int AW    = SPM_AW,
   parameter int DW    = SPM_DW,
   parameter int LW    = SPM_LW,
   parameter int DEPTH = SPM_DEPTH
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          abort,
   input  logic [AW-1:0] base_addr,
   input  logic [AW-1:0] stride,
   input  logic [LW-1:0] len,
   output logic          busy,
   output logic          done,
   output logic          ram_ena,
   output logic          ram_wea,
   output logic          ram_flush,
   output logic [AW-1:0] ram_addr,
   input  logic [DW-1:0] ram_dout,
   input  logic          ram_read_valid,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data,
   output logic          out_last
);
   localparam int CW = $clog2(DEPTH+1);

   logic [1:0]    state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [AW-1:0] stride_q, stride_d;
   logic [LW-1:0] rem_issue_q, rem_issue_d;
   logic [LW-1:0] rem_out_q, rem_out_d;
   logic          inflight_q, inflight_d;
   logic          discard_q, discard_d;
   logic          done_q, done_d;

   logic          fifo_clear, fifo_push, fifo_pop, fifo_empty, fifo_full;
   logic [DW-1:0] fifo_head;
   logic [CW-1:0] fifo_count;
   logic [CW:0]   credit_used;
   logic          issue;

   assign fifo_pop  = !fifo_empty && out_ready;
   assign fifo_push = ram_read_valid && inflight_q && !discard_q;

   // A word leaving this cycle frees its slot now, which keeps issue at one per cycle
   // while downstream is ready; the slot count never exceeds DEPTH.
   assign credit_used = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, fifo_pop};
   assign issue       = (state_q == S_RUN) && (rem_issue_q != '0) && (credit_used < (CW+1)'(DEPTH));

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      stride_d    = stride_q;
      rem_issue_d = rem_issue_q;
      rem_out_d   = rem_out_q;
      inflight_d  = inflight_q;
      discard_d   = discard_q;
      done_d      = 1'b0;
      fifo_clear  = 1'b0;

      if (issue) begin
         addr_d      = addr_q + stride_q;
         rem_issue_d = rem_issue_q - LW'(1);
      end
      // The RAM answers exactly one cycle later, so any read-valid retires the outstanding read.
      if (issue)               inflight_d = 1'b1;
      else if (ram_read_valid) inflight_d = 1'b0;
      if (ram_read_valid)      discard_d  = 1'b0;
      if (fifo_pop)            rem_out_d  = rem_out_q - LW'(1);

      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (len != '0) begin
                  state_d     = S_RUN;
                  addr_d      = base_addr;
                  stride_d    = stride;
                  rem_issue_d = len;
                  rem_out_d   = len;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         S_RUN: begin
            if (issue && rem_issue_q == LW'(1)) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            if (fifo_pop && rem_out_q == LW'(1)) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // A read still owed by the RAM becomes a discard so its late data never reaches the FIFO.
      if (abort) begin
         state_d    = S_IDLE;
         fifo_clear = 1'b1;
         inflight_d = 1'b0;
         discard_d  = issue || (inflight_q && !ram_read_valid) || (discard_q && !ram_read_valid);
         done_d     = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         stride_q    <= '0;
         rem_issue_q <= '0;
         rem_out_q   <= '0;
         inflight_q  <= 1'b0;
         discard_q   <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         stride_q    <= stride_d;
         rem_issue_q <= rem_issue_d;
         rem_out_q   <= rem_out_d;
         inflight_q  <= inflight_d;
         discard_q   <= discard_d;
         done_q      <= done_d;
      end
   end

   stream_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
      .clk_i       (clk),
      .rst_i       (rst),
      .clear_i     (fifo_clear),
      .push_i      (fifo_push),
      .push_data_i (ram_dout),
      .pop_i       (fifo_pop),
      .head_o      (fifo_head),
      .count_o     (fifo_count),
      .empty_o     (fifo_empty),
      .full_o      (fifo_full)
   );

   // The credit rule keeps a capture away from a full FIFO.
   a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(fifo_push && fifo_full));

   assign busy      = (state_q != S_IDLE);
   assign done      = done_q;
   assign ram_ena   = issue;
   assign ram_wea   = 1'b0;
   assign ram_flush = 1'b0;
   assign ram_addr  = issue ? addr_q : '0;
   assign out_valid = !fifo_empty;
   assign out_data  = fifo_empty ? '0 : fifo_head;
   assign out_last  = !fifo_empty && (rem_out_q == LW'(1));

endmodule

// File: tb/tb_spm_read_streamer.sv
module tb_spm_read_streamer;
   localparam int AW = 9;
   localparam int DW = 32;
   localparam int LW = 10;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic [AW-1:0] stride = '0;
   logic [LW-1:0] len = '0;
   logic          busy, done, ram_ena, ram_wea, ram_flush;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_dout;
   logic          ram_read_valid;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [DW-1:0] out_data;
   logic          out_last;

   spm_read_streamer dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .base_addr(base_addr), .stride(stride), .len(len),
      .busy(busy), .done(done),
      .ram_ena(ram_ena), .ram_wea(ram_wea), .ram_flush(ram_flush), .ram_addr(ram_addr),
      .ram_dout(ram_dout), .ram_read_valid(ram_read_valid),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
   );

   always #5 clk = ~clk;

   // One-cycle read RAM model
   logic [DW-1:0] mem [512];
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         ram_read_valid <= 1'b0;
         ram_dout       <= '0;
      end else begin
         ram_read_valid <= ram_ena;
         ram_dout       <= mem[ram_addr];
      end
   end

   typedef struct {
      logic [DW-1:0] d;
      logic          l;
   } exp_t;

   typedef struct {
      int base;
      int strd;
      int ln;
      int mode;            // 0 ready always, 1 toggling, 2 stalled 10 cycles
      int exp_enas;
      int exp_stall_enas;  // -1 when not applicable
      int exp_span;        // last-first issue cycle, -1 when not applicable
   } vec_t;

   exp_t  exp_q[$];
   int    addr_q[$];
   int    total = 0;
   int    bad = 0;
   int    mon_cyc = 0;
   int    ena_cnt, done_cnt, first_ena_cyc, last_ena_cyc, last_hs_cyc, done_cyc;
   logic          prev_stall = 1'b0;
   logic [DW-1:0] prev_data;
   logic          prev_last;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, want %0h", nm, act, exp);
      end
   endtask

   task automatic clr_counts();
      ena_cnt = 0; done_cnt = 0; first_ena_cyc = -1; last_ena_cyc = -1;
      last_hs_cyc = -1; done_cyc = -1;
   endtask

   // Monitor: samples on the falling edge, away from the active edge
   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         mon_cyc++;
         if (done) begin
            done_cnt++;
            done_cyc = mon_cyc;
            chk("done_busy_exclusive", busy, 0);
         end
         if (ram_ena) begin
            ena_cnt++;
            if (first_ena_cyc < 0) first_ena_cyc = mon_cyc;
            last_ena_cyc = mon_cyc;
            if (addr_q.size() == 0) begin
               total++; bad++;
               $display("FAIL ram_addr_extra: got read at %0d, want none", ram_addr);
            end else begin
               chk("ram_addr", ram_addr, addr_q.pop_front());
            end
         end
         if (prev_stall) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_data", out_data, prev_data);
            chk("hold_last", out_last, prev_last);
         end
         if (out_valid && out_ready) begin
            last_hs_cyc = mon_cyc;
            if (exp_q.size() == 0) begin
               total++; bad++;
               $display("FAIL out_extra: got word %0h, want none", out_data);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("out_data", out_data, e.d);
               chk("out_last", out_last, e.l);
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
         prev_last  = out_last;
      end
   end

   task automatic push_expect(input int b, input int s, input int n);
      for (int i = 0; i < n; i++) begin
         exp_t e;
         int a;
         a = (b + i * s) % 512;
         addr_q.push_back(a);
         e.d = mem[a];
         e.l = (i == n - 1);
         exp_q.push_back(e);
      end
   endtask

   task automatic run_burst(input vec_t v);
      int stall_enas = -1;
      int busy_bad = 0;
      bit seen = 0;
      clr_counts();
      push_expect(v.base, v.strd, v.ln);
      @(posedge clk); #1;
      base_addr = AW'(v.base); stride = AW'(v.strd); len = LW'(v.ln); start = 1'b1;
      out_ready = (v.mode != 2);
      @(posedge clk); #1;
      start = 1'b0;
      for (int cyc = 0; cyc < 300; cyc++) begin
         if (done) begin seen = 1; break; end
         if (busy !== (v.ln != 0)) busy_bad++;
         case (v.mode)
            1: out_ready = (cyc % 2 == 0);
            2: begin
               if (cyc == 10) stall_enas = ena_cnt;
               out_ready = (cyc >= 10);
            end
            default: out_ready = 1'b1;
         endcase
         @(posedge clk); #1;
      end
      if (!seen) begin
         total++; bad++;
         $display("FAIL burst_timeout: got no done, want done (base %0d len %0d)", v.base, v.ln);
      end
      repeat (3) @(posedge clk);
      #1;
      chk("done_count", done_cnt, 1);
      chk("ena_count", ena_cnt, v.exp_enas);
      chk("words_left", exp_q.size(), 0);
      chk("addrs_left", addr_q.size(), 0);
      chk("busy_during_burst", busy_bad, 0);
      chk("busy_after", busy, 0);
      if (v.ln != 0) chk("done_after_last_hs", done_cyc - last_hs_cyc, 1);
      if (v.exp_stall_enas >= 0) chk("stall_enas", stall_enas, v.exp_stall_enas);
      if (v.exp_span >= 0) chk("issue_span", last_ena_cyc - first_ena_cyc, v.exp_span);
      exp_q.delete();
      addr_q.delete();
   endtask

   vec_t tv[6];

   initial begin
      for (int i = 0; i < 512; i++) mem[i] = DW'(i + 100);
      tv[0] = '{0,   1,   4, 0, 4, -1, 3};
      tv[1] = '{510, 1,   4, 0, 4, -1, 3};
      tv[2] = '{20,  1,   3, 2, 3,  2, -1};
      tv[3] = '{5,   3,   8, 1, 8, -1, -1};
      tv[4] = '{7,   2,   0, 0, 0, -1, -1};
      tv[5] = '{500, 100, 6, 0, 6, -1, 5};

      // Reset state
      @(posedge clk); #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_ram_ena", ram_ena, 0);
      chk("rst_ram_addr", ram_addr, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_ram_wea", ram_wea, 0);
      chk("rst_ram_flush", ram_flush, 0);
      @(posedge clk); #1;
      rst = 1'b0;

      for (int k = 0; k < 6; k++) run_burst(tv[k]);

      // Abort in the same cycle as a read issue
      clr_counts();
      addr_q.push_back(0);
      @(posedge clk); #1;
      base_addr = '0; stride = AW'(1); len = LW'(4); start = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      chk("abort_issue_cycle", ram_ena, 1);
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_valid_next", out_valid, 0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("abort_discard_valid", out_valid, 0);
      end
      chk("abort_no_done", done_cnt, 0);
      chk("abort_ena_count", ena_cnt, 1);
      addr_q.delete();
      run_burst('{0, 1, 2, 0, 2, -1, 1});

      // Asynchronous reset in the middle of a stalled burst
      clr_counts();
      push_expect(40, 1, 8);
      @(posedge clk); #1;
      base_addr = AW'(40); stride = AW'(1); len = LW'(8); start = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("pre_rst_busy", busy, 1);
      chk("pre_rst_valid", out_valid, 1);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_busy", busy, 0);
      chk("arst_done", done, 0);
      chk("arst_ram_ena", ram_ena, 0);
      chk("arst_ram_addr", ram_addr, 0);
      chk("arst_out_valid", out_valid, 0);
      chk("arst_out_data", out_data, 0);
      chk("arst_out_last", out_last, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      exp_q.delete();
      addr_q.delete();
      run_burst(tv[0]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, want finish within 200000 time units");
      $fatal(1, "watchdog");
   end

endmodule
